// File: rtl/dense_output_streamer_if.sv
// ============================================================================
// dense_output_streamer_if : vector-capture / element-stream / argmax bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface dense_output_streamer_if #(
  parameter int WIDTH       = 16,
  parameter int NUM_OUTPUTS = 16
);
  localparam int IW = $clog2(NUM_OUTPUTS);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data [NUM_OUTPUTS];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [IW-1:0]           out_index;
  logic                    out_last;
  logic                    max_valid;
  logic [IW-1:0]           max_index;
  logic signed [WIDTH-1:0] max_value;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last,
           max_valid, max_index, max_value
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last,
           max_valid, max_index, max_value
  );
endinterface

`default_nettype wire

// File: rtl/dense_output_streamer.sv
// ============================================================================
// dense_output_streamer : captures a dense-layer vector, streams it element by
// element and reports the argmax of the streamed frame.   Rev 1.0
// ============================================================================
`default_nettype none

module dense_output_streamer #(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 10,
  parameter int NUM_OUTPUTS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  dense_output_streamer_if.slave  bus
);

  localparam int IW = $clog2(NUM_OUTPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OUTPUTS - 1);

  if (NUM_OUTPUTS < 2 || NFRAC >= WIDTH) begin : g_bad_params
    $error("dense_output_streamer: illegal NUM_OUTPUTS/NFRAC");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           count_q, count_d;
  logic signed [WIDTH-1:0] max_q,   max_d;
  logic [IW-1:0]           idx_q,   idx_d;
  logic signed [WIDTH-1:0] buf_q [NUM_OUTPUTS];
  logic signed [WIDTH-1:0] cur_w;

  assign cur_w = buf_q[count_q];

  // Buffer needs no reset: every output that exposes it is gated by STREAM.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.in_valid) begin
      buf_q <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_STREAM;
          count_d = '0;
        end
      end
      S_STREAM: begin
        if (bus.out_ready) begin
          // Strict compare keeps the lowest index on ties.
          if (count_q == '0 || cur_w > max_q) begin
            max_d = cur_w;
            idx_d = count_q;
          end
          if (count_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            count_d = count_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_STREAM);
  assign bus.out_data  = (state_q == S_STREAM) ? cur_w   : '0;
  assign bus.out_index = (state_q == S_STREAM) ? count_q : '0;
  assign bus.out_last  = (state_q == S_STREAM) && (count_q == LAST_IDX);
  assign bus.max_valid = (state_q == S_DONE);
  assign bus.max_index = idx_q;
  assign bus.max_value = max_q;

endmodule

`default_nettype wire

// File: tb/tb_dense_output_streamer.sv
// ============================================================================
// tb_dense_output_streamer : directed and random frames against an argmax model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dense_output_streamer;

  localparam int W = 16;
  localparam int N = 4;

  typedef logic signed [W-1:0] vec_t [N];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dense_output_streamer_if #(.WIDTH(W), .NUM_OUTPUTS(N)) bus ();

  dense_output_streamer #(.WIDTH(W), .NFRAC(10), .NUM_OUTPUTS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_max(input vec_t v, output int idx, output logic signed [W-1:0] mx);
    idx = 0;
    mx  = v[0];
    for (int i = 1; i < N; i++) begin
      if (v[i] > mx) begin
        mx  = v[i];
        idx = i;
      end
    end
  endfunction

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_out_valid"}, 16'(bus.out_valid), 16'd0);
    chk({pfx, "_out_last"},  16'(bus.out_last),  16'd0);
    chk({pfx, "_out_data"},  bus.out_data,       16'd0);
    chk({pfx, "_out_index"}, 16'(bus.out_index), 16'd0);
    chk({pfx, "_max_valid"}, 16'(bus.max_valid), 16'd0);
    chk({pfx, "_max_index"}, 16'(bus.max_index), 16'd0);
    chk({pfx, "_max_value"}, bus.max_value,      16'd0);
    chk({pfx, "_in_ready"},  16'(bus.in_ready),  16'd1);
  endtask

  // mode 0: out_ready=1; mode 1: 3-cycle stall at index 2; mode 2: random out_ready.
  task automatic send_frame(input vec_t v, input int mode, input bit hold_next, input vec_t nxt);
    int guard, expi, stall, cyc, ridx;
    logic signed [W-1:0] rmax;
    logic rdy;
    ref_max(v, ridx, rmax);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", 16'(bus.in_ready), 16'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    if (hold_next) begin
      bus.in_data = nxt;
    end else begin
      bus.in_valid = 1'b0;
    end
    expi = 0; stall = 0; cyc = 0;
    while (expi < N && cyc < 40) begin
      chk("out_valid",  16'(bus.out_valid), 16'd1);
      chk("out_data",   bus.out_data,       v[expi]);
      chk("out_index",  16'(bus.out_index), 16'(expi));
      chk("out_last",   16'(bus.out_last),  16'(expi == N - 1));
      chk("busy_ready", 16'(bus.in_ready),  16'd0);
      chk("no_early_max_valid", 16'(bus.max_valid), 16'd0);
      case (mode)
        1:       rdy = !(expi == 2 && stall < 3);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall++;
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) expi++;
      cyc++;
    end
    chk("stream_complete", 16'(expi), 16'(N));
    if (mode == 0) chk("stream_cycles", 16'(cyc), 16'(N));
    if (mode == 1) chk("stall_cycles", 16'(cyc), 16'(N + 3));
    chk("done_out_valid", 16'(bus.out_valid), 16'd0);
    chk("max_valid",      16'(bus.max_valid), 16'd1);
    chk("max_index",      16'(bus.max_index), 16'(ridx));
    chk("max_value",      bus.max_value,      rmax);
    chk("done_in_ready",  16'(bus.in_ready),  16'd0);
    @(negedge clk);
    chk("max_valid_pulse", 16'(bus.max_valid), 16'd0);
    chk("idle_in_ready",   16'(bus.in_ready),  16'd1);
    chk("max_index_hold",  16'(bus.max_index), 16'(ridx));
    chk("max_value_hold",  bus.max_value,      rmax);
  endtask

  initial begin
    vec_t a, b, t, z, r, q;
    int ri;
    logic signed [W-1:0] rv;
    a = '{16'sh0100, 16'sh0400, 16'sh0200, 16'sh0000};
    t = '{16'shFF00, 16'sh0300, 16'sh0300, 16'shFFFF};
    b = '{16'sh8000, 16'sh7FFF, 16'sh0001, 16'sh7FFF};
    z = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data   = '{default: '0};

    @(negedge clk);
    chk_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold_in_ready", 16'(bus.in_ready), 16'd1);
    chk("idle_hold_out_valid", 16'(bus.out_valid), 16'd0);

    send_frame(a, 0, 1'b0, a);
    send_frame(a, 1, 1'b0, a);
    send_frame(t, 0, 1'b0, t);
    // New vector held on in_valid during streaming must wait for in_ready.
    send_frame(a, 0, 1'b1, b);
    send_frame(b, 2, 1'b0, b);

    // Mid-stream reset after index 1 has been accepted.
    bus.in_valid = 1'b1;
    bus.in_data  = t;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_index", 16'(bus.out_index), 16'd2);
    reset = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_max_valid", 16'(bus.max_valid), 16'd0);
      chk("post_rst_no_out_valid", 16'(bus.out_valid), 16'd0);
    end
    ref_max(z, ri, rv);
    chk("model_z_argmax", 16'(ri), 16'd3);
    send_frame(z, 0, 1'b0, z);

    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
        q[i] = W'($urandom);
      end
      send_frame(r, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), q);
      if (bus.in_valid) send_frame(q, 0, 1'b0, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
